// File: rtl/fetch_pc_unit.sv
// Instruction fetch stage: owns the PC, issues instruction-memory requests and fills the IF/ID register.
// A one-entry skip buffer catches a word that returns while decode is stalled.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] branch_pc,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        if_id_valid_q;
    logic [31:0] if_id_instr_q;
    logic [31:0] if_id_pc_q;
    logic [31:0] buf_instr_q;
    logic [31:0] buf_pc_q;
    logic [31:0] fetch_count_q;

    logic [31:0] bpc_plus4;
    logic [31:0] redirect_pc;
    logic        redirect;

    // Branch wins over jump when both arrive in the same cycle.
    assign bpc_plus4   = branch_pc + 32'd4;
    assign redirect    = branch_taken || jump;
    assign redirect_pc = branch_taken ? (bpc_plus4 + branch_target)
                                      : {bpc_plus4[31:28], jump_index, 2'b00};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            if_id_valid_q <= 1'b0;
            if_id_instr_q <= 32'd0;
            if_id_pc_q    <= 32'd0;
            buf_instr_q   <= 32'd0;
            buf_pc_q      <= 32'd0;
            fetch_count_q <= 32'd0;
        end else if (halt) begin
            state_q       <= HALTED;
            if_id_valid_q <= 1'b0;
        end else if (redirect && (state_q != HALTED)) begin
            // Any word returning this cycle belongs to the wrong path and is dropped.
            state_q       <= FETCH;
            pc_q          <= redirect_pc;
            if_id_valid_q <= 1'b0;
            buf_instr_q   <= 32'd0;
            buf_pc_q      <= 32'd0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ready) begin
                        pc_q <= pc_q + 32'd4;
                        if (stall) begin
                            buf_instr_q <= imem_rdata;
                            buf_pc_q    <= pc_q;
                            state_q     <= HOLD;
                        end else begin
                            if_id_valid_q <= 1'b1;
                            if_id_instr_q <= imem_rdata;
                            if_id_pc_q    <= pc_q;
                            fetch_count_q <= fetch_count_q + 32'd1;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_id_valid_q <= 1'b1;
                        if_id_instr_q <= buf_instr_q;
                        if_id_pc_q    <= buf_pc_q;
                        fetch_count_q <= fetch_count_q + 32'd1;
                        state_q       <= FETCH;
                    end
                end
                HALTED: begin
                end
                default: begin
                    state_q <= HALTED;
                end
            endcase
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign if_id_valid = if_id_valid_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = if_id_pc_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, stall buffer, redirects, halt and reset.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] branch_pc;
    logic        jump;
    logic [25:0] jump_index;
    logic        halt;
    logic        imem_ready;
    logic [31:0] word_base;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] fetch_count;

    logic        w_imem_req;
    logic [31:0] w_imem_addr;
    logic        w_if_id_valid;
    logic [31:0] w_if_id_instr;
    logic [31:0] w_if_id_pc;
    logic [31:0] w_fetch_count;
    logic [31:0] w_rdata;

    integer errors = 0;
    integer checks = 0;

    always #5 clk = ~clk;

    // Memory model: word at address A is word_base + A/4.
    assign imem_rdata = word_base + (imem_addr >> 2);
    assign w_rdata    = 32'h5A5A_0000;

    fetch_pc_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .branch_pc(branch_pc),
        .jump(jump), .jump_index(jump_index), .halt(halt),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
        .fetch_count(fetch_count)
    );

    fetch_pc_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .branch_pc(branch_pc),
        .jump(jump), .jump_index(jump_index), .halt(halt),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ready(imem_ready), .imem_rdata(w_rdata),
        .if_id_valid(w_if_id_valid), .if_id_instr(w_if_id_instr), .if_id_pc(w_if_id_pc),
        .fetch_count(w_fetch_count)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall = 0; branch_taken = 0; jump = 0; halt = 0; imem_ready = 0;
        branch_target = 0; branch_pc = 0; jump_index = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; halt = 1; jump = 1; stall = 1; imem_ready = 1; word_base = 32'h0;
        step();
        $display("reset: req=%0b addr=%h valid=%0b count=%0d", imem_req, imem_addr, if_id_valid, fetch_count);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req got=%0b exp=1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=%h", imem_addr, 32'h0); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", if_id_valid); end
        checks++; if (if_id_instr !== 32'h0 || if_id_pc !== 32'h0) begin errors++; $display("FAIL reset_ifid got=%h/%h exp=0/0", if_id_instr, if_id_pc); end
        checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fetch_count); end
        checks++; if (w_imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_addr_param got=%h exp=%h", w_imem_addr, 32'hFFFF_FFFC); end
        idle_inputs(); rst_n = 1;
    endtask

    task automatic test_pc_wrap();
        imem_ready = 1;
        step();
        $display("pc_wrap: addr=%h if_id_pc=%h", w_imem_addr, w_if_id_pc);
        checks++; if (w_imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got=%h exp=%h", w_imem_addr, 32'h0); end
        checks++; if (w_if_id_pc !== 32'hFFFF_FFFC || w_if_id_valid !== 1'b1) begin errors++; $display("FAIL wrap_ifid got=%h/%0b exp=%h/1", w_if_id_pc, w_if_id_valid, 32'hFFFF_FFFC); end
        imem_ready = 0; rst_n = 0;
        step();
        rst_n = 1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_instr [4];
        exp_instr[0] = 32'hA0; exp_instr[1] = 32'hA1; exp_instr[2] = 32'hA2; exp_instr[3] = 32'hA3;
        word_base = 32'hA0; imem_ready = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            $display("seq %0d: valid=%0b instr=%h pc=%h", i, if_id_valid, if_id_instr, if_id_pc);
            checks++;
            if (if_id_valid !== 1'b1 || if_id_instr !== exp_instr[i] || if_id_pc !== 32'(4 * i)) begin
                errors++;
                $display("FAIL seq_ifid%0d got=%0b/%h/%h exp=1/%h/%h", i, if_id_valid, if_id_instr, if_id_pc, exp_instr[i], 32'(4 * i));
            end
        end
        checks++; if (fetch_count !== 32'd4) begin errors++; $display("FAIL seq_count got=%0d exp=4", fetch_count); end
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL seq_addr got=%h exp=%h", imem_addr, 32'h10); end
        imem_ready = 0;
        step();
        $display("not_ready: req=%0b addr=%h pc=%h count=%0d", imem_req, imem_addr, if_id_pc, fetch_count);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL wait_hold got=%0b/%h exp=1/%h", imem_req, imem_addr, 32'h10); end
        checks++; if (if_id_pc !== 32'hC || fetch_count !== 32'd4) begin errors++; $display("FAIL wait_ifid got=%h/%0d exp=%h/4", if_id_pc, fetch_count, 32'hC); end
    endtask

    task automatic test_stall_buffer();
        word_base = 32'hAD; imem_ready = 1; stall = 1;
        step();
        $display("stall: req=%0b addr=%h instr=%h pc=%h", imem_req, imem_addr, if_id_instr, if_id_pc);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req got=%0b exp=0", imem_req); end
        checks++; if (if_id_instr !== 32'hA3 || if_id_pc !== 32'hC) begin errors++; $display("FAIL hold_ifid got=%h/%h exp=%h/%h", if_id_instr, if_id_pc, 32'hA3, 32'hC); end
        step();
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h14 || fetch_count !== 32'd4) begin errors++; $display("FAIL hold_stay got=%0b/%h/%0d exp=0/%h/4", imem_req, imem_addr, fetch_count, 32'h14); end
        stall = 0; imem_ready = 0;
        step();
        $display("release: instr=%h pc=%h addr=%h count=%0d", if_id_instr, if_id_pc, imem_addr, fetch_count);
        checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'hB1 || if_id_pc !== 32'h10) begin errors++; $display("FAIL buf_out got=%0b/%h/%h exp=1/%h/%h", if_id_valid, if_id_instr, if_id_pc, 32'hB1, 32'h10); end
        checks++; if (imem_addr !== 32'h14 || imem_req !== 1'b1 || fetch_count !== 32'd5) begin errors++; $display("FAIL buf_next got=%h/%0b/%0d exp=%h/1/5", imem_addr, imem_req, fetch_count, 32'h14); end
    endtask

    task automatic test_branch();
        branch_pc = 32'h20; branch_target = 32'hFFFF_FFF0; branch_taken = 1; imem_ready = 1; stall = 1;
        step();
        $display("branch: addr=%h valid=%0b count=%0d", imem_addr, if_id_valid, fetch_count);
        checks++; if (if_id_valid !== 1'b0 || fetch_count !== 32'd5) begin errors++; $display("FAIL br_discard got=%0b/%0d exp=0/5", if_id_valid, fetch_count); end
        checks++; if (imem_addr !== 32'h14 || imem_req !== 1'b1) begin errors++; $display("FAIL br_addr got=%h/%0b exp=%h/1", imem_addr, imem_req, 32'h14); end
        branch_pc = 32'h100; branch_target = 32'h40; imem_ready = 0; stall = 0;
        step();
        checks++; if (imem_addr !== 32'h144) begin errors++; $display("FAIL br_fwd got=%h exp=%h", imem_addr, 32'h144); end
        branch_taken = 0; imem_ready = 1; stall = 1;
        step();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL br_hold got=%0b exp=0", imem_req); end
        jump = 1; branch_pc = 32'h3000_0000; jump_index = 26'h0AB_CDE;
        step();
        $display("jump_in_hold: addr=%h req=%0b valid=%0b", imem_addr, imem_req, if_id_valid);
        checks++; if (imem_addr !== 32'h302A_F378 || imem_req !== 1'b1) begin errors++; $display("FAIL jmp_addr got=%h/%0b exp=%h/1", imem_addr, imem_req, 32'h302A_F378); end
        jump = 0; stall = 0; imem_ready = 0;
        step();
        checks++; if (if_id_valid !== 1'b0 || fetch_count !== 32'd5) begin errors++; $display("FAIL jmp_bufdrop got=%0b/%0d exp=0/5", if_id_valid, fetch_count); end
        branch_taken = 1; branch_pc = 32'hFFFF_FFF8; branch_target = 32'h10;
        step();
        checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL br_wrap got=%h exp=%h", imem_addr, 32'hC); end
        branch_taken = 0; jump = 1; branch_pc = 32'hFFFF_FFFC; jump_index = 26'h3FF_FFFF;
        step();
        checks++; if (imem_addr !== 32'h0FFF_FFFC) begin errors++; $display("FAIL jmp_wrap got=%h exp=%h", imem_addr, 32'h0FFF_FFFC); end
        idle_inputs();
    endtask

    task automatic test_branch_jump();
        branch_pc = 32'h40; branch_target = 32'h8; jump_index = 26'h100; branch_taken = 1; jump = 1;
        step();
        $display("br_and_jmp: addr=%h", imem_addr);
        checks++; if (imem_addr !== 32'h4C) begin errors++; $display("FAIL br_prio got=%h exp=%h", imem_addr, 32'h4C); end
        branch_taken = 0; jump = 0;
    endtask

    task automatic test_halt();
        word_base = 32'h7700; imem_ready = 1;
        step();
        checks++; if (if_id_pc !== 32'h4C || if_id_instr !== 32'h7713 || fetch_count !== 32'd6) begin errors++; $display("FAIL pre_halt got=%h/%h/%0d exp=%h/%h/6", if_id_pc, if_id_instr, fetch_count, 32'h4C, 32'h7713); end
        halt = 1; branch_taken = 1;
        step();
        $display("halt: req=%0b valid=%0b addr=%h count=%0d", imem_req, if_id_valid, imem_addr, fetch_count);
        checks++; if (imem_req !== 1'b0 || if_id_valid !== 1'b0) begin errors++; $display("FAIL halt_out got=%0b/%0b exp=0/0", imem_req, if_id_valid); end
        checks++; if (imem_addr !== 32'h50 || fetch_count !== 32'd6) begin errors++; $display("FAIL halt_freeze got=%h/%0d exp=%h/6", imem_addr, fetch_count, 32'h50); end
        halt = 0; jump = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || imem_addr !== 32'h50 || fetch_count !== 32'd6) begin
                errors++;
                $display("FAIL halted%0d got=%0b/%0b/%h/%0d exp=0/0/%h/6", i, imem_req, if_id_valid, imem_addr, fetch_count, 32'h50);
            end
        end
        rst_n = 0;
        step();
        $display("halt_reset: req=%0b addr=%h count=%0d", imem_req, imem_addr, fetch_count);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_count !== 32'd0) begin errors++; $display("FAIL halt_reset got=%0b/%h/%0d exp=1/%h/0", imem_req, imem_addr, fetch_count, 32'h0); end
        idle_inputs(); rst_n = 1;
    endtask

    task automatic test_reset_override();
        word_base = 32'h1234_0000; imem_ready = 1;
        step();
        stall = 1;
        step();
        checks++; if (imem_req !== 1'b0 || if_id_instr !== 32'h1234_0000) begin errors++; $display("FAIL ovr_setup got=%0b/%h exp=0/%h", imem_req, if_id_instr, 32'h1234_0000); end
        rst_n = 0;
        step();
        $display("reset_in_hold: req=%0b addr=%h valid=%0b instr=%h", imem_req, imem_addr, if_id_valid, if_id_instr);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin errors++; $display("FAIL ovr_reset got=%0b/%h/%0b/%h exp=1/0/0/0", imem_req, imem_addr, if_id_valid, if_id_instr); end
        idle_inputs(); rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs(); rst_n = 0; word_base = 0;
        test_reset();
        test_pc_wrap();
        test_sequential();
        test_stall_buffer();
        test_branch();
        test_branch_jump();
        test_halt();
        test_reset_override();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 stall  input  1  decode stage cannot accept a new instruction this cycle.
REQ-005 branch_taken  input  1  branch resolved taken by the downstream branch unit.
REQ-006 branch_target  input  32  sign-extended word offset, already shifted left by 2.
REQ-007 branch_pc  input  32  PC of the branch/jump instruction currently in decode.
REQ-008 jump  input  1  unconditional J-type redirect from decode.
REQ-009 jump_index  input  26  J-type instruction index field.
REQ-010 halt  input  1  stop fetching, single-cycle pulse.
REQ-011 imem_req  output  1  fetch request to instruction memory.
REQ-012 imem_addr  output  32  fetch address; equals pc; bits [1:0] always 0.
REQ-013 imem_ready  input  1  imem_rdata is valid for the current-cycle imem_addr.
REQ-014 imem_rdata  input  32  instruction word.
REQ-015 if_id_valid  output  1  IF/ID register holds a live instruction.
REQ-016 if_id_instr  output  32  fetched instruction.
REQ-017 if_id_pc  output  32  address of if_id_instr.
REQ-018 fetch_count  output  32  count of instructions delivered into IF/ID.

Function
REQ-019 States: FETCH, HOLD, HALTED; imem_req = 1 only in FETCH.
REQ-020 Redirect address: branch gives branch_pc + 4 + branch_target; jump gives {(branch_pc+4)[31:28], jump_index, 2'b00}; both wrap modulo 2^32.
REQ-021 Priority, highest first: rst_n low, halt, redirect (branch_taken over jump), stall, normal fetch.
REQ-022 FETCH, imem_ready=1, no redirect, stall=0: at next edge the IF/ID register loads {1, imem_rdata, pc}, pc advances by 4, fetch_count increments, and the state remains FETCH.
REQ-023 FETCH, imem_ready=1, no redirect, stall=1: the word and pc go into the skip buffer, pc advances by 4, the state moves to HOLD, and the IF/ID register is unchanged.
REQ-024 FETCH, imem_ready=0: pc, the IF/ID register and the state hold; imem_req stays high.
REQ-025 HOLD, stall=0, no redirect: the buffer moves into IF/ID with valid=1, fetch_count increments, and the state moves to FETCH.
REQ-026 HOLD, stall=1: all state holds.
REQ-027 Redirect in any state except HALTED: at next edge pc is set to the redirect address, if_id_valid is cleared, the buffer is discarded, and the state moves to FETCH; an imem_ready in the same cycle is discarded; stall is ignored.
REQ-028 Redirect latency: imem_addr shows the redirect address exactly one cycle after branch_taken or jump is sampled high.
REQ-029 halt from any state: HALTED at next edge, if_id_valid cleared, and pc and fetch_count frozen.
REQ-030 HALTED is left only by reset.
REQ-031 fetch_count wraps from 32'hFFFF_FFFF to 0.
REQ-032 pc wraps from 32'hFFFF_FFFC to 0.

Reset
REQ-033 On a rising edge with rst_n=0: pc=RESET_PC, state=FETCH, if_id_valid=0, if_id_instr=0, if_id_pc=0, buffer cleared, fetch_count=0.
REQ-034 rst_n=0 overrides every other input, including mid-HOLD, mid-stall and HALTED.
REQ-035 The first cycle after reset release has imem_req=1 and imem_addr=RESET_PC.

Verification
REQ-036 Sequential: reset, imem_ready=1 constantly, words 0xA0..0xA3 -> if_id_pc 0,4,8,12 on consecutive cycles; fetch_count=4.
REQ-037 Stall buffer: stall=1 while word 0xB1 at pc 0x10 returns -> HOLD, imem_req=0; stall drops -> if_id_instr=0xB1, if_id_pc=0x10, next imem_addr=0x14.
REQ-038 Branch: branch_pc=0x20, branch_target=0xFFFF_FFF0, branch_taken=1 with imem_ready=1 -> the returned word is discarded, if_id_valid=0, next imem_addr=0x14.
REQ-039 Branch+jump together: branch_pc=0x40, branch_target=0x8, jump_index=0x100 -> branch wins, imem_addr=0x4C.
REQ-040 Halt, then reset: halt pulse -> imem_req=0 and if_id_valid=0 permanently; rst_n=0 for one edge -> imem_addr=RESET_PC, fetch_count=0.
REQ-041 Wrap: RESET_PC=0xFFFF_FFFC, one fetch -> imem_addr=0x0000_0000.
